lcd_pclk_div: RTL and testbench

LCD_PCLK_DIV -- requirements
Module: lcd_pclk_div

---
 rtl/lcd_pclk_div.sv | 83 ++++++++
 tb/tb_lcd_pclk_div.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/lcd_pclk_div.sv
// LCD pixel-clock divider with period-boundary divisor updates.
// Define LCD_PCLK_ID_MAP_EN to take the divisor from lcd_id instead of div_ratio.
module lcd_pclk_div #(
  parameter int CNT_W     = 8,
  parameter int DIV_RESET = 10,
  parameter int DIV_4342  = 10,
  parameter int DIV_7084  = 3,
  parameter int DIV_7016  = 2,
  parameter int DIV_1018  = 2,
  parameter int DIV_DEF   = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] div_ratio,
  input  logic [15:0]      lcd_id,
  output logic             clk_lcd,
  output logic             pclk_rise,
  output logic             pclk_fall,
  output logic             div_ack,
  output logic [CNT_W-1:0] div_cur
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] req_raw;
  logic [CNT_W-1:0] req;
  logic [CNT_W-1:0] n_cnt;
  logic [CNT_W-1:0] n_div;
  logic [CNT_W:0]   n_h;
  logic             bound;
  logic             unused_ok;

`ifdef LCD_PCLK_ID_MAP_EN
  always_comb begin
    req_raw = CNT_W'(DIV_DEF);
    unique case (1'b1)
      (lcd_id == 16'd0): req_raw = CNT_W'(DIV_4342);
      (lcd_id == 16'd1): req_raw = CNT_W'(DIV_7084);
      (lcd_id == 16'd2): req_raw = CNT_W'(DIV_7016);
      (lcd_id == 16'd5): req_raw = CNT_W'(DIV_1018);
      default:           req_raw = CNT_W'(DIV_DEF);
    endcase
  end
  assign unused_ok = ^div_ratio;
`else
  assign req_raw   = div_ratio;
  assign unused_ok = ^lcd_id;
`endif

  assign req = (req_raw == '0) ? CNT_W'(1) : req_raw;

  // >= keeps the counter recoverable even if cnt ever exceeds N-1
  assign bound = (cnt >= div_cur - CNT_W'(1));

  always_comb begin
    n_div = div_cur;
    n_cnt = cnt + CNT_W'(1);
    if (bound) begin
      n_div = req;
      n_cnt = '0;
    end
  end

  assign n_h = ({1'b0, n_div} + (CNT_W+1)'(1)) >> 1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= CNT_W'(DIV_RESET - 1);
      div_cur   <= CNT_W'(DIV_RESET);
      clk_lcd   <= 1'b0;
      pclk_rise <= 1'b0;
      pclk_fall <= 1'b0;
      div_ack   <= 1'b0;
    end else begin
      cnt       <= n_cnt;
      div_cur   <= n_div;
      clk_lcd   <= ({1'b0, n_cnt} < n_h);
      pclk_rise <= (n_cnt == '0);
      pclk_fall <= (n_div >= CNT_W'(2)) && ({1'b0, n_cnt} == n_h);
      div_ack   <= bound && (req != div_cur);
    end
  end

endmodule

// File: tb/tb_lcd_pclk_div.sv
// Directed, table-driven bench for lcd_pclk_div.
// Covers both builds; the LCD_PCLK_ID_MAP_EN build uses lcd_id codes.
module tb_lcd_pclk_div;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] div_ratio = 8'd10;
  logic [15:0] lcd_id = 16'd0;
  logic       clk_lcd;
  logic       pclk_rise;
  logic       pclk_fall;
  logic       div_ack;
  logic [7:0] div_cur;

  int checks = 0;
  int errors = 0;

  lcd_pclk_div dut (
    .clk       (clk),
    .rst       (rst),
    .div_ratio (div_ratio),
    .lcd_id    (lcd_id),
    .clk_lcd   (clk_lcd),
    .pclk_rise (pclk_rise),
    .pclk_fall (pclk_fall),
    .div_ack   (div_ack),
    .div_cur   (div_cur)
  );

  always #5 clk = ~clk;

  typedef struct {
    int code;
    int n;
    int h;
  } vec_t;

  vec_t vt[$];

`ifdef LCD_PCLK_ID_MAP_EN
  localparam int C_TEN = 16'h0007;
  localparam int C_MID = 2;
  localparam int C_FIN = 1;
  localparam int N_FIN = 3;
  localparam int H_FIN = 2;
`else
  localparam int C_TEN = 10;
  localparam int C_MID = 6;
  localparam int C_FIN = 4;
  localparam int N_FIN = 4;
  localparam int H_FIN = 2;
`endif

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int code);
`ifdef LCD_PCLK_ID_MAP_EN
    lcd_id = 16'(code);
`else
    div_ratio = 8'(code);
`endif
  endtask

  task automatic wait_rise();
    int k;
    k = 0;
    step();
    while (!pclk_rise && k < 40) begin
      step();
      k++;
    end
    chk("rise_timeout", int'(pclk_rise), 1);
  endtask

  // Entered in the cnt==0 cycle; leaves in the cnt==0 cycle of the next period.
  task automatic run_period(input int n, input int h);
    chk("p0_clk", int'(clk_lcd), 1);
    chk("p0_fall", int'(pclk_fall), 0);
    for (int c = 1; c < n; c++) begin
      step();
      chk("p_clk", int'(clk_lcd), (c < h) ? 1 : 0);
      chk("p_rise", int'(pclk_rise), 0);
      chk("p_fall", int'(pclk_fall), (c == h) ? 1 : 0);
    end
    step();
    chk("p_wrap_rise", int'(pclk_rise), 1);
    chk("p_wrap_ack", int'(div_ack), 0);
    chk("p_wrap_cur", int'(div_cur), n);
  endtask

  task automatic chk_reset_vals();
    chk("rst_clk", int'(clk_lcd), 0);
    chk("rst_rise", int'(pclk_rise), 0);
    chk("rst_fall", int'(pclk_fall), 0);
    chk("rst_ack", int'(div_ack), 0);
    chk("rst_cur", int'(div_cur), 10);
  endtask

  initial begin
    int prev_n;
`ifdef LCD_PCLK_ID_MAP_EN
    vt.push_back('{0, 10, 5});
    vt.push_back('{1, 3, 2});
    vt.push_back('{5, 2, 1});
    vt.push_back('{5, 2, 1});
    vt.push_back('{16'h0007, 10, 5});
    vt.push_back('{2, 2, 1});
    vt.push_back('{16'hFFFF, 10, 5});
`else
    vt.push_back('{10, 10, 5});
    vt.push_back('{3, 3, 2});
    vt.push_back('{4, 4, 2});
    vt.push_back('{0, 1, 1});
    vt.push_back('{1, 1, 1});
    vt.push_back('{7, 7, 4});
    vt.push_back('{2, 2, 1});
    vt.push_back('{10, 10, 5});
`endif

    set_req(vt[0].code);
    #2 rst = 1'b1;
    #2;
    chk_reset_vals();
    step();
    step();
    chk_reset_vals();
    rst = 1'b0;
    step();
    chk("rel_clk", int'(clk_lcd), 1);
    chk("rel_rise", int'(pclk_rise), 1);
    chk("rel_ack", int'(div_ack), 0);
    chk("rel_cur", int'(div_cur), 10);
    prev_n = 10;

    foreach (vt[i]) begin
      set_req(vt[i].code);
      wait_rise();
      chk("v_cur", int'(div_cur), vt[i].n);
      chk("v_ack", int'(div_ack), (vt[i].n != prev_n) ? 1 : 0);
      run_period(vt[i].n, vt[i].h);
      prev_n = vt[i].n;
    end

    // Mid-period request changes: only the value at the boundary counts.
    set_req(C_TEN);
    wait_rise();
    repeat (3) step();
    set_req(C_MID);
    for (int c = 4; c <= 8; c++) begin
      step();
      chk("hold_clk", int'(clk_lcd), (c < 5) ? 1 : 0);
      chk("hold_rise", int'(pclk_rise), 0);
    end
    set_req(C_FIN);
    step();
    chk("c9_clk", int'(clk_lcd), 0);
    chk("c9_rise", int'(pclk_rise), 0);
    step();
    chk("chg_rise", int'(pclk_rise), 1);
    chk("chg_ack", int'(div_ack), 1);
    chk("chg_cur", int'(div_cur), N_FIN);
    run_period(N_FIN, H_FIN);

    // Async reset in the high cnt==0 cycle of a short period.
    rst = 1'b1;
    #1;
    chk_reset_vals();
    step();
    rst = 1'b0;
    step();
    chk("r1_clk", int'(clk_lcd), 1);
    chk("r1_rise", int'(pclk_rise), 1);
    chk("r1_ack", int'(div_ack), 1);
    chk("r1_cur", int'(div_cur), N_FIN);

    // Async reset at cnt==6 of a 10-cycle period.
    set_req(C_TEN);
    wait_rise();
    chk("r2_pre_ack", int'(div_ack), 1);
    repeat (6) step();
    chk("r2_c6_clk", int'(clk_lcd), 0);
    #2 rst = 1'b1;
    #1;
    chk_reset_vals();
    step();
    rst = 1'b0;
    step();
    chk("r2_clk", int'(clk_lcd), 1);
    chk("r2_rise", int'(pclk_rise), 1);
    chk("r2_ack", int'(div_ack), 0);
    chk("r2_cur", int'(div_cur), 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
